// File: rtl/sequential_divider.sv
// Multi-cycle signed integer divider: restoring shift-subtract, one quotient bit per clock.
// Operands are converted to magnitudes on accept, and the signs are reapplied in a final fix-up
// cycle. Quotient truncates toward zero and the remainder takes the sign of the dividend.
module sequential_divider #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StFix
  } state_e;

  state_e           r_state;
  logic [WIDTH-1:0] r_dvd;       // dividend magnitude, shifts out as quotient bits shift in
  logic [WIDTH-1:0] r_dvs;       // divisor magnitude
  logic [WIDTH-1:0] r_rem;       // partial remainder, always < r_dvs between iterations
  logic [CntW-1:0]  r_cnt;
  logic             r_sign_q;
  logic             r_sign_r;
  logic             r_dz;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_busy;
  logic             r_done;
  logic             r_div_by_zero;

  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic [WIDTH:0]   w_shift;
  logic             w_ge;
  logic [WIDTH-1:0] w_sub;
  logic [WIDTH-1:0] w_q_fix;
  logic [WIDTH-1:0] w_r_mag;
  logic [WIDTH-1:0] w_r_fix;

  // Operand magnitudes, trial subtraction and sign fix-up values.
  always_comb begin
    // -(-2^(W-1)) wraps to the same pattern, which read unsigned is the correct magnitude.
    w_abs_a = A[WIDTH-1] ? (~A + 1'b1) : A;
    w_abs_b = B[WIDTH-1] ? (~B + 1'b1) : B;
    w_shift = {r_rem, r_dvd[WIDTH-1]};
    w_ge    = (w_shift >= {1'b0, r_dvs});
    // Difference fits in WIDTH bits whenever w_ge holds, so the low bits suffice.
    w_sub   = w_shift[WIDTH-1:0] - r_dvs;
    w_q_fix = r_sign_q ? (~r_dvd + 1'b1) : r_dvd;
    // On divide-by-zero the untouched dividend magnitude becomes the remainder.
    w_r_mag = r_dz ? r_dvd : r_rem;
    w_r_fix = r_sign_r ? (~w_r_mag + 1'b1) : w_r_mag;
  end

  // Control FSM with datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= StIdle;
      r_dvd         <= '0;
      r_dvs         <= '0;
      r_rem         <= '0;
      r_cnt         <= '0;
      r_sign_q      <= 1'b0;
      r_sign_r      <= 1'b0;
      r_dz          <= 1'b0;
      r_quotient    <= '0;
      r_remainder   <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_div_by_zero <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        StIdle: begin
          r_busy <= start;
          if (start) begin
            r_dvd    <= w_abs_a;
            r_dvs    <= w_abs_b;
            r_rem    <= '0;
            r_cnt    <= '0;
            r_sign_q <= A[WIDTH-1] ^ B[WIDTH-1];
            r_sign_r <= A[WIDTH-1];
            r_dz     <= (B == '0);
            r_state  <= (B == '0) ? StFix : StCalc;
          end
        end
        StCalc: begin
          r_rem <= w_ge ? w_sub : w_shift[WIDTH-1:0];
          r_dvd <= {r_dvd[WIDTH-2:0], w_ge};
          r_cnt <= r_cnt + CntW'(1);
          if (r_cnt == CntW'(WIDTH - 1)) begin
            r_state <= StFix;
          end
        end
        StFix: begin
          r_quotient    <= r_dz ? '1 : w_q_fix;
          r_remainder   <= w_r_fix;
          r_div_by_zero <= r_dz;
          r_done        <= 1'b1;
          // busy stays high through the done cycle and drops on the following edge.
          r_state       <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign Quotient    = r_quotient;
  assign Remainder   = r_remainder;
  assign busy        = r_busy;
  assign done        = r_done;
  assign div_by_zero = r_div_by_zero;

endmodule

// File: tb/tb_sequential_divider.sv
// Directed bench for sequential_divider at WIDTH=32: latency, signed quadrants, divide-by-zero,
// overflow, ignored start, mid-operation reset and back-to-back issue.
module tb_sequential_divider;

  logic        clk;
  logic        rst;
  logic        i_start;
  logic [31:0] i_a;
  logic [31:0] i_b;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        busy;
  logic        done;
  logic        div_by_zero;

  int n_cmp;
  int n_err;

  sequential_divider #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (i_start),
    .A           (i_a),
    .B           (i_b),
    .Quotient    (quotient),
    .Remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issues one request; lat returns the number of edges after the accept edge until done (100 = none).
  task automatic do_div(input logic [31:0] a, input logic [31:0] b, output int lat);
    @(negedge clk);
    i_start = 1'b1;
    i_a     = a;
    i_b     = b;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    i_start = 1'b0;
    i_a = '0;
    i_b = '0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({quotient, remainder, busy, done, div_by_zero} !== 67'd0) begin
      $display("FAIL reset_outputs: got Q=%h R=%h busy=%b done=%b dz=%b, want all 0",
               quotient, remainder, busy, done, div_by_zero);
      n_err++;
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int lat;
    bit busy_ok;
    @(negedge clk);
    i_start = 1'b1;
    i_a = 32'd100;
    i_b = 32'd7;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    lat = 0;
    busy_ok = 1'b1;
    while (done !== 1'b1 && lat < 100) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
    n_cmp++;
    if (lat != 33) begin
      $display("FAIL basic_latency: got %0d edges, want 33", lat);
      n_err++;
    end
    n_cmp++;
    if (!busy_ok || busy !== 1'b1) begin
      $display("FAIL basic_busy_high: busy dropped (now %b), want 1 through done cycle", busy);
      n_err++;
    end
    n_cmp++;
    if (quotient !== 32'd14 || remainder !== 32'd2 || div_by_zero !== 1'b0) begin
      $display("FAIL basic_result: got Q=%0d R=%0d dz=%b, want Q=14 R=2 dz=0",
               quotient, remainder, div_by_zero);
      n_err++;
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL basic_after_done: got done=%b busy=%b, want 0 0", done, busy);
      n_err++;
    end
    n_cmp++;
    if (quotient !== 32'd14 || remainder !== 32'd2) begin
      $display("FAIL basic_hold: got Q=%0d R=%0d, want 14 2", quotient, remainder);
      n_err++;
    end
  endtask

  task automatic test_quadrants();
    logic [31:0] ta [5];
    logic [31:0] tb [5];
    logic [31:0] tq [5];
    logic [31:0] tr [5];
    int lat;
    ta[0] = -32'sd100;       tb[0] = 32'd7;          tq[0] = 32'hFFFF_FFF2; tr[0] = 32'hFFFF_FFFE;
    ta[1] = 32'd8100;        tb[1] = -32'sd90;       tq[1] = -32'sd90;      tr[1] = 32'd0;
    ta[2] = -32'sd2222;      tb[2] = -32'sd111;      tq[2] = 32'd20;        tr[2] = -32'sd2;
    ta[3] = 32'h8000_0000;   tb[3] = 32'hFFFF_FFFF;  tq[3] = 32'h8000_0000; tr[3] = 32'd0;
    ta[4] = 32'h8000_0000;   tb[4] = 32'd1;          tq[4] = 32'h8000_0000; tr[4] = 32'd0;
    for (int i = 0; i < 5; i++) begin
      do_div(ta[i], tb[i], lat);
      n_cmp++;
      if (lat != 33 || quotient !== tq[i] || remainder !== tr[i] || div_by_zero !== 1'b0) begin
        $display("FAIL signed_%0d: %h/%h got lat=%0d Q=%h R=%h dz=%b, want lat=33 Q=%h R=%h dz=0",
                 i, ta[i], tb[i], lat, quotient, remainder, div_by_zero, tq[i], tr[i]);
        n_err++;
      end
    end
  endtask

  task automatic test_div_zero();
    int lat;
    do_div(32'd98765, 32'd0, lat);
    n_cmp++;
    if (lat != 1) begin
      $display("FAIL dz_latency: got %0d edges, want 1", lat);
      n_err++;
    end
    n_cmp++;
    if (quotient !== 32'hFFFF_FFFF || remainder !== 32'd98765 || div_by_zero !== 1'b1) begin
      $display("FAIL dz_result: got Q=%h R=%0d dz=%b, want Q=ffffffff R=98765 dz=1",
               quotient, remainder, div_by_zero);
      n_err++;
    end
    do_div(-32'sd5, 32'd0, lat);
    n_cmp++;
    if (lat != 1 || quotient !== 32'hFFFF_FFFF || remainder !== 32'hFFFF_FFFB) begin
      $display("FAIL dz_negative: got lat=%0d Q=%h R=%h, want lat=1 Q=ffffffff R=fffffffb",
               lat, quotient, remainder);
      n_err++;
    end
    do_div(32'd77, 32'd8, lat);
    n_cmp++;
    if (div_by_zero !== 1'b0 || quotient !== 32'd9 || remainder !== 32'd5) begin
      $display("FAIL dz_clear: got Q=%0d R=%0d dz=%b, want Q=9 R=5 dz=0",
               quotient, remainder, div_by_zero);
      n_err++;
    end
  endtask

  task automatic test_ignore_start();
    int n_done;
    int done_edge;
    logic [31:0] q_seen;
    logic [31:0] r_seen;
    n_done = 0;
    done_edge = -1;
    q_seen = '0;
    r_seen = '0;
    @(negedge clk);
    i_start = 1'b1;
    i_a = 32'd100;
    i_b = 32'd7;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    for (int e = 1; e <= 45; e++) begin
      @(posedge clk);
      #1;
      if (e == 9) begin
        i_start = 1'b1;
        i_a = 32'd50;
        i_b = 32'd5;
      end
      if (e == 10) i_start = 1'b0;
      if (done === 1'b1) begin
        n_done++;
        done_edge = e;
        q_seen = quotient;
        r_seen = remainder;
      end
    end
    n_cmp++;
    if (n_done != 1 || done_edge != 33) begin
      $display("FAIL ignore_start_done: got %0d pulses (last edge %0d), want 1 at edge 33",
               n_done, done_edge);
      n_err++;
    end
    n_cmp++;
    if (q_seen !== 32'd14 || r_seen !== 32'd2) begin
      $display("FAIL ignore_start_result: got Q=%0d R=%0d, want 14 2", q_seen, r_seen);
      n_err++;
    end
  endtask

  task automatic test_reset_abort();
    int n_done;
    int lat;
    n_done = 0;
    @(negedge clk);
    i_start = 1'b1;
    i_a = 32'd1000;
    i_b = 32'd3;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    for (int e = 1; e <= 15; e++) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    n_cmp++;
    if ({quotient, remainder, busy, done, div_by_zero} !== 67'd0) begin
      $display("FAIL abort_outputs: got Q=%h R=%h busy=%b done=%b dz=%b, want all 0",
               quotient, remainder, busy, done, div_by_zero);
      n_err++;
    end
    for (int e = 0; e < 40; e++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) n_done++;
    end
    n_cmp++;
    if (n_done != 0) begin
      $display("FAIL abort_no_done: got %0d done pulses, want 0", n_done);
      n_err++;
    end
    do_div(32'd77, 32'd8, lat);
    n_cmp++;
    if (lat != 33 || quotient !== 32'd9 || remainder !== 32'd5) begin
      $display("FAIL abort_fresh: got lat=%0d Q=%0d R=%0d, want lat=33 Q=9 R=5",
               lat, quotient, remainder);
      n_err++;
    end
  endtask

  task automatic test_back_to_back();
    int n_done;
    int edge0;
    int edge1;
    logic [31:0] q0;
    logic [31:0] r0;
    logic [31:0] q1;
    logic [31:0] r1;
    n_done = 0;
    edge0 = -1;
    edge1 = -1;
    q0 = '0;
    r0 = '0;
    q1 = '0;
    r1 = '0;
    @(negedge clk);
    i_start = 1'b1;
    i_a = 32'd100;
    i_b = 32'd7;
    @(posedge clk);
    #1;
    // Operands change while start stays high; the running divide must not see them.
    i_a = 32'd77;
    i_b = 32'd8;
    for (int e = 1; e <= 80; e++) begin
      @(posedge clk);
      #1;
      if (e == 34) i_start = 1'b0;
      if (done === 1'b1) begin
        if (n_done == 0) begin
          edge0 = e;
          q0 = quotient;
          r0 = remainder;
        end else begin
          edge1 = e;
          q1 = quotient;
          r1 = remainder;
        end
        n_done++;
      end
    end
    n_cmp++;
    if (n_done != 2 || edge0 != 33 || edge1 != 67) begin
      $display("FAIL b2b_timing: got %0d pulses at edges %0d,%0d, want 2 at 33,67",
               n_done, edge0, edge1);
      n_err++;
    end
    n_cmp++;
    if (q0 !== 32'd14 || r0 !== 32'd2 || q1 !== 32'd9 || r1 !== 32'd5) begin
      $display("FAIL b2b_results: got %0d/%0d then %0d/%0d, want 14/2 then 9/5", q0, r0, q1, r1);
      n_err++;
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_basic();
    test_quadrants();
    test_div_zero();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
